button_pulse_debouncer: RTL and testbench

Front-end conditioning stage for a push-button or switch on a gpio pin, feeding the parity FSM and similar single-bit FSM consumers. Synchronises the asynchronous raw input and rejects contact bounce by requiring a minimum stable time. Produces a clean debounced level, one-cycle press and release pulses, and a wrapping press counter, so each physical press advances a downstream FSM exactly once.

---
 rtl/button_pulse_debouncer.sv | 152 +++++++++++++++
 tb/tb_button_pulse_debouncer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_debouncer.sv
// button_pulse_debouncer: two-flop synchroniser plus a stability-counting
// FSM that turns a bouncy push-button into a clean level and edge pulses.
//
// Ports:
//   gclk        in   system clock, all state updates on the rising edge
//   resetn      in   synchronous active-low reset
//   btn_raw     in   asynchronous, bouncy button/switch input
//   btn_level   out  debounced level (registered)
//   btn_press   out  one-cycle pulse on a committed 0->1 transition
//   btn_release out  one-cycle pulse on a committed 1->0 transition
//   press_count out  committed presses since reset, wraps 255->0
//
// A new value must be seen on the synchronised input for STABLE_CYCLES
// consecutive samples before it is committed.  Any sample at the old
// value during the wait sends the FSM back to its previous stable state.

module button_pulse_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic       gclk,
    input  logic       resetn,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync1;
    logic                 s;

    state_t               state;
    state_t               state_n;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_n;

    logic                 press_n;
    logic                 release_n;
    logic [7:0]           count_n;
    logic                 level_n;

    // Synchroniser: only s is allowed into the FSM.
    always_ff @(posedge gclk) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            s     <= sync1;
        end
    end

    // State register; all outputs are registered here as well.
    always_ff @(posedge gclk) begin
        if (!resetn) begin
            state       <= IDLE_LOW;
            cnt         <= CNT_ZERO;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            btn_level   <= level_n;
            btn_press   <= press_n;
            btn_release <= release_n;
            press_count <= count_n;
        end
    end

    // Next-state logic.  The counter holds how many consecutive samples
    // of the candidate value have been seen, so a commit happens on the
    // STABLE_CYCLES-th sample (counter already at STABLE_CYCLES-1).
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        count_n   = press_count;
        unique case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n   = CNT_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_n = IDLE_LOW;
                    cnt_n   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    cnt_n   = CNT_ZERO;
                    press_n = 1'b1;
                    count_n = press_count + 8'd1;
                end else begin
                    cnt_n   = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_n = WAIT_LOW;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n   = CNT_ZERO;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_n = HIGH;
                    cnt_n   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE_LOW;
                    cnt_n     = CNT_ZERO;
                    release_n = 1'b1;
                end else begin
                    cnt_n     = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE_LOW;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so btn_level leaves a flop
    // and changes on the same edge as the press/release pulse.
    always_comb begin
        level_n = 1'b0;
        if ((state_n == HIGH) || (state_n == WAIT_LOW)) begin
            level_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_button_pulse_debouncer.sv
// tb_button_pulse_debouncer: table vectors, directed corner sequences
// and random runs checked against a run-length reference model.

module tb_button_pulse_debouncer;

    localparam int S = 4;

    logic       gclk;
    logic       resetn;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic [7:0] press_count;

    button_pulse_debouncer #(
        .STABLE_CYCLES(S),
        .CNT_WIDTH    (8)
    ) dut (
        .gclk       (gclk),
        .resetn     (resetn),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_count(press_count)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    typedef struct {
        logic       raw;
        logic       rn;
        logic       lvl;
        logic       prs;
        logic       rel;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    // Reference model: raw input delayed two edges, then a count of
    // consecutive samples differing from the committed level.
    logic       hist[$];
    logic       m_level;
    logic       m_press;
    logic       m_rel;
    int         m_count;
    int         m_run;

    int         n_press = 0;
    int         n_rel   = 0;
    logic       lvl_dropped;

    task automatic chk(input string name,
                       input logic [10:0] got,
                       input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic raw, input logic rn);
        logic seen;
        if (!rn) begin
            m_level = 1'b0;
            m_press = 1'b0;
            m_rel   = 1'b0;
            m_count = 0;
            m_run   = 0;
            hist    = {1'b0, 1'b0};
        end else begin
            seen = hist.pop_front();
            hist.push_back(raw);
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (seen != m_level) m_run++;
            else m_run = 0;
            if (m_run == S) begin
                m_level = seen;
                m_run   = 0;
                if (seen) begin
                    m_press = 1'b1;
                    m_count = (m_count + 1) % 256;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic raw, input logic rn);
        btn_raw = raw;
        resetn  = rn;
        @(posedge gclk);
        model_edge(raw, rn);
        #1;
        chk("model",
            {btn_level, btn_press, btn_release, press_count},
            {m_level, m_press, m_rel, m_count[7:0]});
        if (btn_press === 1'b1) n_press++;
        if (btn_release === 1'b1) n_rel++;
        if (btn_level !== 1'b1) lvl_dropped = 1'b1;
    endtask

    task automatic hold(input logic raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b1);
    endtask

    int p0;
    int r0;
    logic v;
    int len;

    initial begin
        btn_raw = 1'b0;
        resetn  = 1'b0;

        // Reset with raw high, then clean press and release.
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1});
        for (int i = 0; i < 14; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});

        foreach (vecs[i]) begin
            step(vecs[i].raw, vecs[i].rn);
            chk($sformatf("vec%0d", i),
                {btn_level, btn_press, btn_release, press_count},
                {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].cnt});
        end

        // Bounce: 3 high / 1 low five times, then a stable high.
        step(1'b0, 1'b0);
        hold(1'b0, 4);
        p0 = n_press;
        for (int b = 0; b < 5; b++) begin
            hold(1'b1, 3);
            hold(1'b0, 1);
        end
        chk("bounce_quiet", 11'(n_press - p0), 11'd0);
        hold(1'b1, 10);
        chk("bounce_one", 11'(n_press - p0), 11'd1);
        chk("bounce_cnt", {3'd0, press_count}, 11'd1);

        // Glitch while HIGH: level must hold, no release.
        hold(1'b1, 4);
        r0 = n_rel;
        lvl_dropped = 1'b0;
        hold(1'b0, 2);
        hold(1'b1, 10);
        chk("glitch_lvl", {10'd0, lvl_dropped}, 11'd0);
        chk("glitch_rel", 11'(n_rel - r0), 11'd0);
        hold(1'b0, 8);
        chk("glitch_end", 11'(n_rel - r0), 11'd1);

        // Wrap: 256 clean presses from a fresh reset.
        step(1'b0, 1'b0);
        hold(1'b0, 2);
        p0 = n_press;
        for (int k = 0; k < 255; k++) begin
            hold(1'b1, 6);
            hold(1'b0, 6);
        end
        chk("wrap_255", {3'd0, press_count}, 11'd255);
        hold(1'b1, 6);
        hold(1'b0, 6);
        chk("wrap_0", {3'd0, press_count}, 11'd0);
        chk("wrap_pulses", 11'(n_press - p0), 11'd256);

        // Reset during WAIT_HIGH with counter at 2.
        step(1'b0, 1'b0);
        hold(1'b0, 3);
        p0 = n_press;
        hold(1'b1, 4);
        step(1'b1, 1'b0);
        chk("abort_out",
            {btn_level, btn_press, btn_release, press_count},
            11'd0);
        hold(1'b1, 5);
        chk("abort_none", 11'(n_press - p0), 11'd0);
        hold(1'b1, 1);
        chk("abort_fresh", {9'd0, btn_level, btn_press}, 11'd3);
        chk("abort_cnt", {3'd0, press_count}, 11'd1);

        // Random runs with occasional resets.
        step(1'b0, 1'b0);
        v = 1'b0;
        for (int r = 0; r < 400; r++) begin
            len = $urandom_range(1, 9);
            v = ~v;
            for (int k = 0; k < len; k++)
                step(v, ($urandom_range(0, 199) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
